// File: rtl/text_pixel_renderer_pkg.sv
// Shared display constants, control state encoding and the built-in glyph table
// for the text pixel renderer.
package text_pixel_renderer_pkg;

    localparam int unsigned COLS         = 48;
    localparam int unsigned ROWS         = 32;
    localparam int unsigned BLINK_FRAMES = 30;

    localparam logic [7:0] RGB_FG     = 8'hFF;
    localparam logic [7:0] RGB_BG     = 8'h00;
    localparam logic [7:0] RGB_BORDER = 8'h02;
    localparam logic [7:0] RGB_OFF    = 8'h00;

    localparam logic [6:0] SPACE = 7'h20;

    typedef enum logic {
        IDLE,
        CLEAR
    } ctrl_state_e;

    // Built-in glyph table; codes without an entry render as blank cells.
    function automatic logic [7:0] glyph_row(input logic [6:0] code, input logic [2:0] row);
        logic [7:0] r;
        r = '0;
        case (code)
            7'h41: begin
                case (row)
                    3'd0:             r = 8'h18;
                    3'd1:             r = 8'h3C;
                    3'd2, 3'd3:       r = 8'h66;
                    3'd4:             r = 8'h7E;
                    3'd5, 3'd6:       r = 8'h66;
                    default:          r = 8'h00;
                endcase
            end
            7'h42: begin
                case (row)
                    3'd0, 3'd3, 3'd6: r = 8'h7C;
                    3'd7:             r = 8'h00;
                    default:          r = 8'h66;
                endcase
            end
            7'h7F:   r = 8'hFF;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/font_rom_8x8.sv
// 1024 x 8 synchronous font ROM indexed by {ascii[6:0], row[2:0]}; one-cycle latency.
module font_rom_8x8
    import text_pixel_renderer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [9:0] addr_i,
    output logic [7:0] data_o
);

    logic [7:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= glyph_row(addr_i[9:3], addr_i[2:0]);
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/text_pixel_renderer.sv
// Character-cell pixel renderer: text buffer, clear sequencer, font lookup and
// blinking cursor, producing RGB332 with syncs delayed to match (latency 4).
module text_pixel_renderer
    import text_pixel_renderer_pkg::*;
#(
    parameter int unsigned COLS         = text_pixel_renderer_pkg::COLS,
    parameter int unsigned ROWS         = text_pixel_renderer_pkg::ROWS,
    parameter logic [7:0]  FG           = RGB_FG,
    parameter logic [7:0]  BG           = RGB_BG,
    parameter logic [7:0]  BORDER       = RGB_BORDER,
    parameter int unsigned BLINK_FRAMES = text_pixel_renderer_pkg::BLINK_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       video_on_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       is_in_grid,
    input  logic [5:0] char_x,
    input  logic [5:0] char_y,
    input  logic [3:0] px_x,
    input  logic [3:0] px_y,
    input  logic       wr_en,
    input  logic [5:0] wr_col,
    input  logic [5:0] wr_row,
    input  logic [6:0] wr_char,
    input  logic       clr,
    input  logic       cursor_en,
    input  logic [5:0] cursor_col,
    input  logic [5:0] cursor_row,
    output logic       busy,
    output logic [7:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       video_on_out
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned AW    = $clog2(CELLS);
    localparam int unsigned BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [5:0]  COLS_L = 6'(COLS);
    localparam logic [5:0]  ROWS_L = 6'(ROWS);

    ctrl_state_e     state_q;
    logic [AW-1:0]   clr_addr_q;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [6:0]      wdata;
    logic [6:0]      mem [CELLS];

    logic            von1_q, hs1_q, vs1_q, ok1_q, cur1_q;
    logic [3:0]      pxx1_q, pxy1_q;
    logic [AW-1:0]   addr1_q;
    logic            von2_q, hs2_q, vs2_q, ok2_q, cur2_q;
    logic [3:0]      pxx2_q, pxy2_q;
    logic [6:0]      code2_q;
    logic            von3_q, hs3_q, vs3_q, ok3_q, cur3_q;
    logic [3:0]      pxx3_q, pxy3_q;
    logic [7:0]      font_row;
    logic [7:0]      rgb_q, rgb_d;
    logic            hs4_q, vs4_q, von4_q;

    logic [BW-1:0]   frame_q;
    logic            phase_q;
    logic            glyph_on;

    assign busy = (state_q == CLEAR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                    end
                end
                CLEAR: begin
                    if (clr) begin
                        clr_addr_q <= '0;
                    end else if (clr_addr_q == AW'(CELLS - 1)) begin
                        state_q    <= IDLE;
                        clr_addr_q <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    // The sweep owns the write port; a user write coinciding with clr is dropped.
    always_comb begin
        we    = 1'b0;
        waddr = clr_addr_q;
        wdata = SPACE;
        if (state_q == CLEAR) begin
            we = 1'b1;
        end else if (wr_en && !clr && (wr_col < COLS_L) && (wr_row < ROWS_L)) begin
            we    = 1'b1;
            waddr = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
            wdata = wr_char;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            code2_q <= '0;
        end else begin
            code2_q <= mem[addr1_q];
        end
    end

    font_rom_8x8 u_font (
        .clk_i  (clk),
        .rst_ni (rst),
        .addr_i ({code2_q, pxy2_q[2:0]}),
        .data_o (font_row)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            {von1_q, ok1_q, cur1_q} <= '0;
            {hs1_q, vs1_q}          <= '1;
            pxx1_q  <= '0;
            pxy1_q  <= '0;
            addr1_q <= '0;
            {von2_q, ok2_q, cur2_q} <= '0;
            {hs2_q, vs2_q}          <= '1;
            pxx2_q  <= '0;
            pxy2_q  <= '0;
            {von3_q, ok3_q, cur3_q} <= '0;
            {hs3_q, vs3_q}          <= '1;
            pxx3_q  <= '0;
            pxy3_q  <= '0;
            rgb_q   <= '0;
            {hs4_q, vs4_q} <= '1;
            von4_q  <= 1'b0;
        end else begin
            von1_q  <= video_on_in;
            hs1_q   <= hsync_in;
            vs1_q   <= vsync_in;
            ok1_q   <= is_in_grid && (char_x < COLS_L) && (char_y < ROWS_L);
            cur1_q  <= cursor_en && (char_x == cursor_col) && (char_y == cursor_row);
            pxx1_q  <= px_x;
            pxy1_q  <= px_y;
            addr1_q <= AW'(char_y) * AW'(COLS) + AW'(char_x);
            {von2_q, hs2_q, vs2_q, ok2_q, cur2_q} <= {von1_q, hs1_q, vs1_q, ok1_q, cur1_q};
            pxx2_q  <= pxx1_q;
            pxy2_q  <= pxy1_q;
            {von3_q, hs3_q, vs3_q, ok3_q, cur3_q} <= {von2_q, hs2_q, vs2_q, ok2_q, cur2_q};
            pxx3_q  <= pxx2_q;
            pxy3_q  <= pxy2_q;
            rgb_q   <= rgb_d;
            hs4_q   <= hs3_q;
            vs4_q   <= vs3_q;
            von4_q  <= von3_q;
        end
    end

    assign glyph_on = (pxx3_q < 4'd8) && (pxy3_q < 4'd8) && font_row[3'd7 - pxx3_q[2:0]];

    always_comb begin
        rgb_d = BG;
        if (!von3_q) begin
            rgb_d = RGB_OFF;
        end else if (!ok3_q) begin
            rgb_d = BORDER;
        end else if (busy) begin
            rgb_d = BG;
        end else begin
            rgb_d = (glyph_on ^ (cur3_q && phase_q)) ? FG : BG;
        end
    end

    // Frame boundary = falling edge seen between the first two registered vsync stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_q <= '0;
            phase_q <= 1'b1;
        end else if (vs2_q && !vs1_q) begin
            if (frame_q == BW'(BLINK_FRAMES - 1)) begin
                frame_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                frame_q <= frame_q + 1'b1;
            end
        end
    end

    assign rgb          = rgb_q;
    assign hsync_out    = hs4_q;
    assign vsync_out    = vs4_q;
    assign video_on_out = von4_q;

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Directed self-checking bench for text_pixel_renderer.
module tb_text_pixel_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic       video_on_in, hsync_in, vsync_in, is_in_grid;
    logic [5:0] char_x, char_y;
    logic [3:0] px_x, px_y;
    logic       wr_en;
    logic [5:0] wr_col, wr_row;
    logic [6:0] wr_char;
    logic       clr, cursor_en;
    logic [5:0] cursor_col, cursor_row;
    logic       busy;
    logic [7:0] rgb;
    logic       hsync_out, vsync_out, video_on_out;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [7:0] FGC = 8'hFF;
    localparam logic [7:0] BGC = 8'h00;
    localparam logic [7:0] BDC = 8'h02;

    text_pixel_renderer dut (
        .clk          (clk),
        .rst          (rst),
        .video_on_in  (video_on_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .is_in_grid   (is_in_grid),
        .char_x       (char_x),
        .char_y       (char_y),
        .px_x         (px_x),
        .px_y         (px_y),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_row       (wr_row),
        .wr_char      (wr_char),
        .clr          (clr),
        .cursor_en    (cursor_en),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
        .busy         (busy),
        .rgb          (rgb),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .video_on_out (video_on_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] c, input logic [5:0] r, input logic [6:0] ch);
        wr_en = 1'b1; wr_col = c; wr_row = r; wr_char = ch;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic pix(input string tag, input logic [5:0] cx, input logic [5:0] cy,
                       input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp);
        is_in_grid = 1'b1; video_on_in = 1'b1;
        char_x = cx; char_y = cy; px_x = x; px_y = y;
        step(5);
        chk(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic vfalls(input int n);
        for (int k = 0; k < n; k++) begin
            vsync_in = 1'b0; step(2);
            vsync_in = 1'b1; step(2);
        end
    endtask

    task automatic count_busy(output int cnt);
        int guard;
        cnt = 0; guard = 0;
        while (busy && guard < 5000) begin
            cnt++; guard++;
            step(1);
        end
    endtask

    initial begin
        logic [7:0]  arow;
        logic [15:0] hp, vp, op;
        int          bc;

        rst = 1'b0; video_on_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        is_in_grid = 1'b1; char_x = '0; char_y = '0; px_x = '0; px_y = '0;
        wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0; clr = 1'b0;
        cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
        step(6);
        chk("reset_rgb", 32'(rgb), 32'h00);
        chk("reset_hsync", 32'(hsync_out), 32'h1);
        chk("reset_vsync", 32'(vsync_out), 32'h1);
        chk("reset_von", 32'(video_on_out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h1);

        hsync_in = 1'b1; vsync_in = 1'b1;
        rst = 1'b1;
        count_busy(bc);
        chk("busy_after_reset", 32'(bc), 32'd1536);

        pix("blank_0_0", 6'd0, 6'd0, 4'd3, 4'd1, BGC);
        pix("blank_47_31", 6'd47, 6'd31, 4'd3, 4'd4, BGC);
        pix("blank_10_20", 6'd10, 6'd20, 4'd2, 4'd6, BGC);

        // 'A' row 1 = 8'h3C, columns 8-9 are spacing
        wr(6'd0, 6'd0, 7'h41);
        arow = 8'h3C;
        is_in_grid = 1'b1; video_on_in = 1'b1; char_x = '0; char_y = '0; px_y = 4'd1;
        for (int i = 0; i < 13; i++) begin
            if (i < 10) px_x = 4'(i);
            step(1);
            if (i >= 3) chk($sformatf("A_row1_px%0d", i - 3), 32'(rgb),
                            32'((i - 3) < 8 && arow[7 - (i - 3)] ? FGC : BGC));
        end

        wr(6'd48, 6'd0, 7'h41);
        wr(6'd63, 6'd0, 7'h41);
        wr(6'd0, 6'd32, 7'h41);
        pix("oor_col48", 6'd0, 6'd1, 4'd2, 4'd1, BGC);
        pix("oor_col63", 6'd15, 6'd1, 4'd2, 4'd1, BGC);
        pix("border_x48", 6'd48, 6'd0, 4'd2, 4'd1, BDC);
        pix("border_y32", 6'd0, 6'd32, 4'd2, 4'd1, BDC);
        is_in_grid = 1'b0; char_x = '0; char_y = '0; step(5);
        chk("border_not_in_grid", 32'(rgb), 32'(BDC));

        wr(6'd47, 6'd31, 7'h42);
        pix("B_r0_px1", 6'd47, 6'd31, 4'd1, 4'd0, FGC);
        pix("B_r0_px0", 6'd47, 6'd31, 4'd0, 4'd0, BGC);
        wr(6'd1, 6'd0, 7'h7F);
        pix("blk_px7_7", 6'd1, 6'd0, 4'd7, 4'd7, FGC);
        pix("blk_px8_3", 6'd1, 6'd0, 4'd8, 4'd3, BGC);
        pix("blk_px3_9", 6'd1, 6'd0, 4'd3, 4'd9, BGC);

        clr = 1'b1; wr_en = 1'b1; wr_col = 6'd2; wr_row = 6'd2; wr_char = 7'h7F;
        step(1);
        clr = 1'b0; wr_en = 1'b0;
        chk("busy_after_clr", 32'(busy), 32'h1);
        repeat (700) @(posedge clk);
        @(negedge clk);
        clr = 1'b1; step(1); clr = 1'b0;
        count_busy(bc);
        chk("busy_restart_len", 32'(bc), 32'd1536);
        pix("cleared_A", 6'd0, 6'd0, 4'd3, 4'd1, BGC);
        pix("cleared_blk", 6'd1, 6'd0, 4'd3, 4'd3, BGC);
        pix("clr_wins_wr", 6'd2, 6'd2, 4'd3, 4'd3, BGC);

        wr(6'd5, 6'd3, 7'h41);
        cursor_en = 1'b1; cursor_col = 6'd5; cursor_row = 6'd3;
        pix("cur_f0_glyph", 6'd5, 6'd3, 4'd2, 4'd1, BGC);
        pix("cur_f0_space", 6'd5, 6'd3, 4'd8, 4'd8, FGC);
        pix("cur_other_cell", 6'd6, 6'd3, 4'd8, 4'd8, BGC);
        vfalls(29);
        pix("cur_f29_glyph", 6'd5, 6'd3, 4'd2, 4'd1, BGC);
        vfalls(1);
        pix("cur_f30_glyph", 6'd5, 6'd3, 4'd2, 4'd1, FGC);
        pix("cur_f30_space", 6'd5, 6'd3, 4'd8, 4'd8, BGC);
        vfalls(29);
        pix("cur_f59_glyph", 6'd5, 6'd3, 4'd2, 4'd1, FGC);
        vfalls(1);
        pix("cur_f60_glyph", 6'd5, 6'd3, 4'd2, 4'd1, BGC);
        cursor_en = 1'b0;
        pix("cur_disabled", 6'd5, 6'd3, 4'd2, 4'd1, FGC);

        hp = 16'hB2E5; vp = 16'h6D1B; op = 16'hF0C3;
        is_in_grid = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (i < 16) begin
                hsync_in = hp[i]; vsync_in = vp[i]; video_on_in = op[i];
            end
            step(1);
            if (i >= 3) begin
                chk($sformatf("hsync_d%0d", i - 3), 32'(hsync_out), 32'(hp[i - 3]));
                chk($sformatf("vsync_d%0d", i - 3), 32'(vsync_out), 32'(vp[i - 3]));
                chk($sformatf("von_d%0d", i - 3), 32'(video_on_out), 32'(op[i - 3]));
                chk($sformatf("rgb_von%0d", i - 3), 32'(rgb), 32'(op[i - 3] ? BDC : 8'h00));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
